alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor of the reservation-station ALU for the Tomasulo RV32I core. Accepts one issued instruction per cycle from the RS over a valid/ready handshake and carries it through `STAGES` elastic register stages. It presents `{ROB tag, result}` to the CDB arbiter with backpressure, and drops everything in flight on a pipeline flush (branch mispredict). Optional RV32M multiply support is compiled in by macro.

## Interface
- `XLEN`, default 32: operand and result width.
- `TAG_W`, default 4: ROB position width.
- `STAGES`, default 2: pipeline depth, legal range 1..4.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. **One clock; reset is asynchronous and active-high.**
- `rdy` in 1: global enable. When low, no state changes.
- `flush` in 1: mispredict clear; kills all in-flight entries.
- `in_valid` in 1: RS presents an instruction.
- `in_ready` out 1: the unit accepts this cycle.
- `in_op` in 6: opcode id, using the shared op-map encoding.
- `in_vj`, `in_vk` in XLEN: register operands.
- `in_imm` in XLEN: sign-extended immediate (`A`).
- `in_tag` in TAG_W: ROB position.
- `out_valid` out 1: result available to the CDB.
- `out_ready` in 1: CDB arbiter takes the result.
- `out_tag` out TAG_W: ROB position of the result.
- `out_val` out XLEN: result.
- `occupancy` out $clog2(STAGES+1): number of valid stages.

## Operation
- Result is computed combinationally from the input fields and registered into stage 0 on acceptance. Later stages only carry `{valid, tag, val}`.
- R-type `ADD`/`SUB`/`SLL`/`SLT`/`SLTU`/`XOR`/`SRL`/`SRA`/`OR`/`AND` operate on vj and vk. Shift amount is `vk[4:0]`.
- I-type `ADDI`/`SLTI`/`SLTIU`/`XORI`/`ORI`/`ANDI` operate on vj and imm. `SLLI`/`SRLI`/`SRAI` use `imm[4:0]` only.
- `JALR`: (vj+imm) & ~1.
- Branches `BEQ`/`BNE`/`BLT`/`BGE`/`BLTU`/`BGEU` produce 1 if the condition holds, else 0.
- Signed compares and `SRA`/`SRAI` are two's-complement. Add/sub wrap modulo 2^XLEN.
- Any other opcode: result 0, still retired with its tag. The unit never deadlocks on an unknown op.
- Elastic pipeline: stage k loads from stage k-1 when stage k is empty or is advancing this cycle.
- `in_ready = rdy & ~flush & (stage0 empty | stage0 advancing)`.
- `out_valid = last stage valid & ~flush`. The last stage advances (empties) when `out_valid & out_ready & rdy`.
- `flush` with `rdy=1`: all valid bits clear at the next edge, the input is not accepted, and `occupancy` becomes 0.
- `flush` takes priority over acceptance and output.
- `rdy=0`: all registers hold, `in_ready=0`, and outputs stay stable. `out_valid` may stay high but nothing is consumed.
- Reset, at any time including mid-operation, clears state immediately: all valid bits 0, `out_valid=0`, `out_tag=0`, `out_val=0`, `occupancy=0`. `in_ready` is 0 while `rst` is high.

## Timing
- Latency: an instruction accepted at edge N is visible with `out_valid=1` after edge N+STAGES-1, i.e. STAGES cycles from issue to CDB, with no stall.
- Throughput: 1 instruction per cycle while `out_ready=1`.
- Full unit (`occupancy==STAGES`) with `out_ready=0`: `in_ready=0`.
- Full unit with `out_ready=1`: accept and retire in the same cycle, so occupancy is unchanged.
- Simultaneous accept and retire: occupancy is unchanged. Accept only: +1. Retire only: -1.
- Output holds its tag and value unchanged across backpressure cycles until taken.

## Configuration
- `ALU_MUL_EN` defined: adds `MUL`, `MULH`, `MULHSU`, `MULHU` on vj and vk, producing the low, signed-high, signed×unsigned-high and unsigned-high XLEN bits.
  - The product is formed in stage 0 with same latency and handshake as other ops.
  - Requires the four opcode ids in the shared op map.
- `ALU_MUL_EN` undefined: these ids fall into the unknown-op case (result 0) and no multiplier is synthesised.

## Structure
- Opcode id defines, including the four multiply ids guarded by `ALU_MUL_EN`, live in the shared op-map include header used by decoder, RS and ALU.
- One sub-module, `alu_core`: purely combinational `op/vj/vk/imm -> val`. It holds all arithmetic and the `ALU_MUL_EN` branch.
- `alu_pipe` owns only the stage registers, handshake, flush and occupancy.

## Test plan
- Reset mid-stream with 2 entries in flight, `rst` pulsed between edges -> `out_valid=0`, `occupancy=0` immediately, with no clock edge needed.
- `STAGES=2`: issue ADD vj=5 vk=7 tag=3 at edge 0 -> at edge 1 `out_valid=1`, `out_tag=3`, `out_val=12`. Then SRAI vj=0x80000000 imm=0x24 -> 0xF8000000, using `imm[4:0]=4`.
- Back-to-back issue of SLT vj=-1 vk=1 (->1) and SLTU vj=-1 vk=1 (->0) with `out_ready=0` -> `in_ready` falls once occupancy=2. Raising `out_ready` drains in order with tags preserved.
- `flush` asserted with occupancy=2 and `in_valid=1` -> next cycle occupancy=0, no result for any of the three tags.
- `rdy=0` for 3 cycles with a result pending -> tag and value are held, nothing consumed, no new accept.
- With `ALU_MUL_EN`: MULH vj=0xFFFFFFFF vk=0xFFFFFFFF -> 0, and MULHU on the same operands -> 0xFFFFFFFE. Without `ALU_MUL_EN`, the same ids -> 0.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared op map for the decoder, reservation stations and ALU.
// The multiply ids are always reserved; ALU_MUL_EN decides whether alu_core decodes them.
package alu_pipe_pkg;

  localparam int OP_W = 6;

  typedef logic [OP_W-1:0] op_t;

  // R-type register/register operations
  localparam op_t OP_ADD    = 6'd0;
  localparam op_t OP_SUB    = 6'd1;
  localparam op_t OP_SLL    = 6'd2;
  localparam op_t OP_SLT    = 6'd3;
  localparam op_t OP_SLTU   = 6'd4;
  localparam op_t OP_XOR    = 6'd5;
  localparam op_t OP_SRL    = 6'd6;
  localparam op_t OP_SRA    = 6'd7;
  localparam op_t OP_OR     = 6'd8;
  localparam op_t OP_AND    = 6'd9;

  // I-type register/immediate operations
  localparam op_t OP_ADDI   = 6'd10;
  localparam op_t OP_SLTI   = 6'd11;
  localparam op_t OP_SLTIU  = 6'd12;
  localparam op_t OP_XORI   = 6'd13;
  localparam op_t OP_ORI    = 6'd14;
  localparam op_t OP_ANDI   = 6'd15;
  localparam op_t OP_SLLI   = 6'd16;
  localparam op_t OP_SRLI   = 6'd17;
  localparam op_t OP_SRAI   = 6'd18;

  localparam op_t OP_JALR   = 6'd19;

  // Branch conditions resolve to 1/0
  localparam op_t OP_BEQ    = 6'd20;
  localparam op_t OP_BNE    = 6'd21;
  localparam op_t OP_BLT    = 6'd22;
  localparam op_t OP_BGE    = 6'd23;
  localparam op_t OP_BLTU   = 6'd24;
  localparam op_t OP_BGEU   = 6'd25;

  localparam op_t OP_MUL    = 6'd26;
  localparam op_t OP_MULH   = 6'd27;
  localparam op_t OP_MULHSU = 6'd28;
  localparam op_t OP_MULHU  = 6'd29;

  // True for the ops whose first multiplier operand is treated as signed.
  function automatic logic mul_a_signed(input op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // Only MULH treats the second operand as signed.
  function automatic logic mul_b_signed(input op_t op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// alu_core: purely combinational op/vj/vk/imm -> val for the pipelined RS ALU.
// Defining ALU_MUL_EN adds the RV32M multiply family; otherwise those ids return 0.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] vj,
  input  logic [XLEN-1:0] vk,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] val
);

  logic [4:0]      sh_r;
  logic [4:0]      sh_i;
  logic [XLEN-1:0] sum_i;

  assign sh_r  = vk[4:0];
  assign sh_i  = imm[4:0];
  assign sum_i = vj + imm;

`ifdef ALU_MUL_EN
  // One shared 2*XLEN multiplier; the operand extension picks the product flavour.
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] mul_prod;

  always_comb begin
    mul_a    = mul_a_signed(op) ? {{XLEN{vj[XLEN-1]}}, vj} : {{XLEN{1'b0}}, vj};
    mul_b    = mul_b_signed(op) ? {{XLEN{vk[XLEN-1]}}, vk} : {{XLEN{1'b0}}, vk};
    mul_prod = mul_a * mul_b;
  end
`endif

  always_comb begin
    val = '0;
    case (op)
      OP_ADD:    val = vj + vk;
      OP_SUB:    val = vj - vk;
      OP_SLL:    val = vj << sh_r;
      OP_SLT:    val = XLEN'($signed(vj) < $signed(vk));
      OP_SLTU:   val = XLEN'(vj < vk);
      OP_XOR:    val = vj ^ vk;
      OP_SRL:    val = vj >> sh_r;
      OP_SRA:    val = $unsigned($signed(vj) >>> sh_r);
      OP_OR:     val = vj | vk;
      OP_AND:    val = vj & vk;
      OP_ADDI:   val = sum_i;
      OP_SLTI:   val = XLEN'($signed(vj) < $signed(imm));
      OP_SLTIU:  val = XLEN'(vj < imm);
      OP_XORI:   val = vj ^ imm;
      OP_ORI:    val = vj | imm;
      OP_ANDI:   val = vj & imm;
      OP_SLLI:   val = vj << sh_i;
      OP_SRLI:   val = vj >> sh_i;
      OP_SRAI:   val = $unsigned($signed(vj) >>> sh_i);
      OP_JALR:   val = {sum_i[XLEN-1:1], 1'b0};
      OP_BEQ:    val = XLEN'(vj == vk);
      OP_BNE:    val = XLEN'(vj != vk);
      OP_BLT:    val = XLEN'($signed(vj) < $signed(vk));
      OP_BGE:    val = XLEN'($signed(vj) >= $signed(vk));
      OP_BLTU:   val = XLEN'(vj < vk);
      OP_BGEU:   val = XLEN'(vj >= vk);
`ifdef ALU_MUL_EN
      OP_MUL:    val = mul_prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  val = mul_prod[2*XLEN-1:XLEN];
`endif
      default:   val = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: elastic STAGES-deep ALU between the reservation station and the CDB arbiter.
// Multiply support follows ALU_MUL_EN inside alu_core; this file only handles staging.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int TAG_W  = 4,
  parameter  int STAGES = 2,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [XLEN-1:0]   in_vj,
  input  logic [XLEN-1:0]   in_vk,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [XLEN-1:0]   out_val,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [XLEN-1:0]   val_q [STAGES];
  logic [STAGES:0]   take;
  logic [XLEN-1:0]   core_val;

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .op  (in_op),
    .vj  (in_vj),
    .vk  (in_vk),
    .imm (in_imm),
    .val (core_val)
  );

  // take[k]: stage k may load this cycle. The CDB acts as a virtual stage STAGES,
  // so a stage is free when empty or when everything downstream of it moves.
  always_comb begin
    take         = '0;
    take[STAGES] = out_ready & rdy & ~flush;
    for (int k = STAGES - 1; k >= 0; k--) begin
      take[k] = rdy & ~flush & (~valid_q[k] | take[k+1]);
    end
  end

  assign in_ready  = take[0] & ~rst;
  assign out_valid = valid_q[LAST] & ~flush;
  assign out_tag   = tag_q[LAST];
  assign out_val   = val_q[LAST];

  // Payload only updates behind a valid source so a stalled output stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k] <= '0;
        val_q[k] <= '0;
      end
    end else if (rdy && flush) begin
      valid_q <= '0;
    end else begin
      if (take[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          tag_q[0] <= in_tag;
          val_q[0] <= core_val;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (take[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            tag_q[k] <= tag_q[k-1];
            val_q[k] <= val_q[k-1];
          end
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(valid_q[k]);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios followed by random traffic,
// all compared against an in-order queue model with an arithmetic reference ALU.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int XLEN   = 32;
  localparam int TAG_W  = 4;
  localparam int STAGES = 2;
  localparam int OCC_W  = $clog2(STAGES + 1);

`ifdef ALU_MUL_EN
  localparam logic [31:0] MULHU_EXP = 32'hFFFFFFFE;
`else
  localparam logic [31:0] MULHU_EXP = 32'h0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OP_W-1:0]  in_op = '0;
  logic [XLEN-1:0]  in_vj = '0;
  logic [XLEN-1:0]  in_vk = '0;
  logic [XLEN-1:0]  in_imm = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_val;
  logic [OCC_W-1:0] occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
    int               age;
  } item_t;

  item_t model_q[$];

  alu_pipe #(
    .XLEN   (XLEN),
    .TAG_W  (TAG_W),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_vj     (in_vj),
    .in_vk     (in_vk),
    .in_imm    (in_imm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_val   (out_val),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sraRef(input logic [31:0] a, input int unsigned s);
    logic [31:0] r;
    logic [31:0] ones;
    ones = 32'hFFFFFFFF;
    r = a >> s;
    if (a[31] && s != 0) r = r | ~(ones >> s);
    return r;
  endfunction

  function automatic logic [31:0] refAlu(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] imm);
    int          sa;
    int          sb;
    int          si;
    int unsigned rs;
    int unsigned is;
    longint      p;
    sa = a;
    sb = b;
    si = imm;
    rs = int'(b[4:0]);
    is = int'(imm[4:0]);
    p  = 0;
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_SLL:   return a << rs;
      OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:   return a ^ b;
      OP_SRL:   return a >> rs;
      OP_SRA:   return sraRef(a, rs);
      OP_OR:    return a | b;
      OP_AND:   return a & b;
      OP_ADDI:  return a + imm;
      OP_SLTI:  return (sa < si) ? 32'd1 : 32'd0;
      OP_SLTIU: return (a < imm) ? 32'd1 : 32'd0;
      OP_XORI:  return a ^ imm;
      OP_ORI:   return a | imm;
      OP_ANDI:  return a & imm;
      OP_SLLI:  return a << is;
      OP_SRLI:  return a >> is;
      OP_SRAI:  return sraRef(a, is);
      OP_JALR:  return (a + imm) & 32'hFFFFFFFE;
      OP_BEQ:   return (a == b) ? 32'd1 : 32'd0;
      OP_BNE:   return (a != b) ? 32'd1 : 32'd0;
      OP_BLT:   return (sa < sb) ? 32'd1 : 32'd0;
      OP_BGE:   return (sa >= sb) ? 32'd1 : 32'd0;
      OP_BLTU:  return (a < b) ? 32'd1 : 32'd0;
      OP_BGEU:  return (a >= b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
      OP_MULH: begin
        p = longint'(sa) * longint'(sb);
        return p[63:32];
      end
      OP_MULHSU: begin
        p = longint'(sa) * longint'(b);
        return p[63:32];
      end
      OP_MULHU: begin
        p = longint'(a) * longint'(b);
        return p[63:32];
      end
`endif
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkHead(input string name, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    checkOutput({name, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({name, "_tag"}, 64'(out_tag), 64'(tag));
    checkOutput({name, "_val"}, 64'(out_val), 64'(val));
  endtask

  // One clock of traffic: drive, check against the model mid-cycle, then advance the model.
  task automatic applyStimulus(input logic iv, input logic [5:0] op, input logic [31:0] vj,
                               input logic [31:0] vk, input logic [31:0] imm,
                               input logic [TAG_W-1:0] tag, input logic ordy,
                               input logic r, input logic fl);
    logic  e_ov;
    logic  e_ir;
    logic  acc;
    logic  ret;
    item_t it;
    in_valid  = iv;
    in_op     = op;
    in_vj     = vj;
    in_vk     = vk;
    in_imm    = imm;
    in_tag    = tag;
    out_ready = ordy;
    rdy       = r;
    flush     = fl;
    @(negedge clk);
    e_ov = (model_q.size() > 0) && (model_q[0].age >= STAGES - 1) && !fl;
    e_ir = r && !fl && ((model_q.size() < STAGES) || ordy);
    checkOutput("in_ready", 64'(in_ready), 64'(e_ir));
    checkOutput("out_valid", 64'(out_valid), 64'(e_ov));
    checkOutput("occupancy", 64'(occupancy), 64'(model_q.size()));
    if (e_ov) begin
      checkOutput("out_tag", 64'(out_tag), 64'(model_q[0].tag));
      checkOutput("out_val", 64'(out_val), 64'(model_q[0].val));
    end
    acc = iv && e_ir;
    ret = e_ov && ordy && r;
    @(posedge clk);
    #1;
    if (r) begin
      if (fl) begin
        model_q.delete();
      end else begin
        if (ret) void'(model_q.pop_front());
        foreach (model_q[i]) model_q[i].age++;
        if (acc) begin
          it.tag = tag;
          it.val = refAlu(op, vj, vk, imm);
          it.age = 0;
          model_q.push_back(it);
        end
      end
    end
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 32'h0, '0, ordy, 1'b1, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("rst_out_val", 64'(out_val), 64'd0);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;

    applyStimulus(1'b1, OP_ADD, 32'd5, 32'd7, 32'd0, 4'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("add_not_yet", 64'(out_valid), 64'd0);
    idle(1'b0);
    checkHead("add", 4'd3, 32'd12);
    idle(1'b1);

    applyStimulus(1'b1, OP_SRAI, 32'h80000000, 32'h0, 32'h24, 4'd5, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    checkHead("srai", 4'd5, 32'hF8000000);
    idle(1'b1);

    applyStimulus(1'b1, OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd2, 1'b0, 1'b1, 1'b0);
    checkOutput("full_occ", 64'(occupancy), 64'd2);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 4'd4, 1'b0, 1'b1, 1'b0);
    checkHead("slt", 4'd1, 32'd1);
    idle(1'b1);
    checkHead("sltu", 4'd2, 32'd0);
    idle(1'b1);

    applyStimulus(1'b1, OP_XOR, 32'h0F, 32'hF0, 32'd0, 4'd8, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_OR, 32'h11, 32'h22, 32'd0, 4'd10, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_ADD, 32'd2, 32'd2, 32'd0, 4'd9, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_occ", 64'(occupancy), 64'd0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    idle(1'b1);
    idle(1'b1);

    applyStimulus(1'b1, OP_AND, 32'hF0F0, 32'hFF00, 32'd0, 4'd11, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, OP_ADD, 32'd3, 32'd4, 32'd0, 4'd12, 1'b1, 1'b0, 1'b0);
    checkHead("hold", 4'd11, 32'hF000);
    checkOutput("hold_occ", 64'(occupancy), 64'd1);
    idle(1'b1);

    applyStimulus(1'b1, OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 4'd6, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 4'd7, 1'b0, 1'b1, 1'b0);
    checkHead("mulh", 4'd6, 32'h0);
    idle(1'b1);
    checkHead("mulhu", 4'd7, MULHU_EXP);
    idle(1'b1);

    applyStimulus(1'b1, OP_SUB, 32'd10, 32'd3, 32'd0, 4'd13, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_SLL, 32'd1, 32'd4, 32'd0, 4'd14, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    checkOutput("mid_occ_before", 64'(occupancy), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_occ", 64'(occupancy), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("mid_rst_out_tag", 64'(out_tag), 64'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 40)),
                    pickOperand(), pickOperand(), pickOperand(),
                    TAG_W'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0));
    end
    for (int n = 0; n < 6; n++) idle(1'b1);
    checkOutput("final_occ", 64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
